// File: rtl/ser_pkg.sv
// Shared types and line levels for the serial link.
// Reused by the matching receiver.
package ser_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/ser_tx_bit_tick.sv
// Bit-period timer: one-cycle tick at the last clock of each bit.
// Held at zero while clear is high so a new bit starts aligned.
module bit_tick #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int TW = $clog2(CLKS_PER_BIT + 1);

  logic [TW-1:0] cnt;

  assign tick = (cnt == TW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (rst || clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ser_tx.sv
// Framed parallel-in/serial-out transmitter:
// start bit, WIDTH data bits (MSB or LSB first), stop bit.
module ser_tx
  import ser_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_paralelo,
  input  logic             lsb_first,
  output logic             in_ready,
  output logic             out_serial,
  output logic             busy,
  output logic             done
);

  localparam int BW = $clog2(WIDTH + 1);

  tx_state_t        state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_nxt;
  logic [BW-1:0]    bit_cnt;
  logic             lsb;
  logic             tick;
  logic             cur_bit;
  logic             nxt_bit;
  logic             last_bit;

  assign in_ready = (state == IDLE);
  assign last_bit = (bit_cnt == BW'(WIDTH - 1));

  bit_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clear(in_ready),
    .tick (tick)
  );

  always_comb begin
    shreg_nxt = lsb ? (shreg >> 1) : (shreg << 1);
    cur_bit   = lsb ? shreg[0] : shreg[WIDTH-1];
    nxt_bit   = lsb ? shreg[1] : shreg[WIDTH-2];
  end

  // Line level is registered one edge ahead of the bit it belongs to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      lsb        <= 1'b0;
      out_serial <= LINE_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          out_serial <= LINE_IDLE;
          busy       <= 1'b0;
          if (in_valid) begin
            shreg      <= in_paralelo;
            lsb        <= lsb_first;
            bit_cnt    <= '0;
            state      <= START;
            out_serial <= START_BIT;
            busy       <= 1'b1;
          end
        end
        START: begin
          if (tick) begin
            state      <= DATA;
            out_serial <= cur_bit;
          end
        end
        DATA: begin
          if (tick) begin
            shreg   <= shreg_nxt;
            bit_cnt <= bit_cnt + 1'b1;
            if (last_bit) begin
              state      <= STOP;
              out_serial <= STOP_BIT;
            end else begin
              out_serial <= nxt_bit;
            end
          end
        end
        STOP: begin
          if (tick) begin
            state      <= IDLE;
            out_serial <= LINE_IDLE;
            busy       <= 1'b0;
            done       <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ser_tx.sv
// Directed bench for ser_tx: default timing plus a 1-clock-per-bit instance.
// Inputs driven and outputs sampled on the falling edge.
module tb_ser_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_paralelo;
  logic       lsb_first;
  logic       in_ready;
  logic       out_serial;
  logic       busy;
  logic       done;

  logic       f_valid;
  logic [7:0] f_data;
  logic       f_lsb;
  logic       f_ready;
  logic       f_line;
  logic       f_busy;
  logic       f_done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ser_tx #(
    .WIDTH       (8),
    .CLKS_PER_BIT(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_paralelo(in_paralelo),
    .lsb_first  (lsb_first),
    .in_ready   (in_ready),
    .out_serial (out_serial),
    .busy       (busy),
    .done       (done)
  );

  ser_tx #(
    .WIDTH       (8),
    .CLKS_PER_BIT(1)
  ) dut_fast (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (f_valid),
    .in_paralelo(f_data),
    .lsb_first  (f_lsb),
    .in_ready   (f_ready),
    .out_serial (f_line),
    .busy       (f_busy),
    .done       (f_done)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected line level in frame cycle k (1..40), 4 clocks per bit.
  function automatic logic exp_line(input logic [7:0] d, input logic lsb,
                                    input int k);
    int idx;
    if (k <= 4) return 1'b0;
    if (k > 36) return 1'b1;
    idx = (k - 1) / 4 - 1;
    return lsb ? d[idx] : d[7-idx];
  endfunction

  // Presents a word; returns at the falling edge of frame cycle 1.
  task automatic start_frame(input logic [7:0] d, input logic lsb);
    in_paralelo = d;
    lsb_first   = lsb;
    in_valid    = 1'b1;
    @(negedge clk);
  endtask

  // Called at frame cycle 1; returns in the done cycle (cycle 41).
  task automatic check_frame(input logic [7:0] d, input logic lsb);
    check("ready_in_frame", in_ready, 1'b0);
    for (int k = 1; k <= 40; k++) begin
      check($sformatf("line_%02h_c%0d", d, k), out_serial, exp_line(d, lsb, k));
      check("busy", busy, 1'b1);
      check("done_early", done, 1'b0);
      if (k < 40) @(negedge clk);
    end
    @(negedge clk);
    check("done", done, 1'b1);
    check("ready_done", in_ready, 1'b1);
    check("busy_done", busy, 1'b0);
    check("line_done", out_serial, 1'b1);
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [9:0] pat;
    rst         = 1'b1;
    in_valid    = 1'b1;
    in_paralelo = 8'hA5;
    lsb_first   = 1'b0;
    f_valid     = 1'b1;
    f_data      = 8'h81;
    f_lsb       = 1'b0;

    // reset with in_valid asserted
    repeat (3) @(negedge clk);
    check("rst_line", out_serial, 1'b1);
    check("rst_ready", in_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    rst      = 1'b0;
    in_valid = 1'b0;
    f_valid  = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("post_rst_line", out_serial, 1'b1);
      check("post_rst_busy", busy, 1'b0);
    end

    // MSB first A5
    start_frame(8'hA5, 1'b0);
    in_valid    = 1'b0;
    in_paralelo = 8'h00;
    check_frame(8'hA5, 1'b0);
    @(negedge clk);
    check("done_one_cycle", done, 1'b0);

    // LSB first A5, then 01
    start_frame(8'hA5, 1'b1);
    in_valid  = 1'b0;
    lsb_first = 1'b0;
    check_frame(8'hA5, 1'b1);
    @(negedge clk);
    start_frame(8'h01, 1'b1);
    in_valid    = 1'b0;
    in_paralelo = 8'hFF;
    lsb_first   = 1'b0;
    check_frame(8'h01, 1'b1);
    @(negedge clk);

    // in_valid held, data changes mid-frame, back-to-back accept
    start_frame(8'h3C, 1'b0);
    in_paralelo = 8'hC3;
    check_frame(8'h3C, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    check_frame(8'hC3, 1'b0);
    @(negedge clk);

    // reset during data bit 3 (cycles 17..20)
    start_frame(8'hA5, 1'b0);
    in_valid = 1'b0;
    for (int k = 1; k <= 18; k++) begin
      check("pre_rst_line", out_serial, exp_line(8'hA5, 1'b0, k));
      if (k < 18) @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_line", out_serial, 1'b1);
    check("abort_ready", in_ready, 1'b1);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    repeat (5) begin
      @(negedge clk);
      check("abort_no_done", done, 1'b0);
      check("abort_idle_line", out_serial, 1'b1);
    end
    start_frame(8'hFF, 1'b0);
    in_valid = 1'b0;
    check_frame(8'hFF, 1'b0);
    @(negedge clk);

    // one clock per bit, 81 MSB first
    pat     = 10'b0100000011;
    f_data  = 8'h81;
    f_lsb   = 1'b0;
    f_valid = 1'b1;
    @(negedge clk);
    f_valid = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      check($sformatf("fast_line_c%0d", k), f_line, pat[10-k]);
      check("fast_busy", f_busy, 1'b1);
      check("fast_done_early", f_done, 1'b0);
      if (k < 10) @(negedge clk);
    end
    @(negedge clk);
    check("fast_done", f_done, 1'b1);
    check("fast_ready", f_ready, 1'b1);
    check("fast_line_done", f_line, 1'b1);
    @(negedge clk);
    check("fast_done_clear", f_done, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
